// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier: N/2+1 iterations over (N+2)-bit extended
// operands, so signed and unsigned products share one datapath and one latency.
module booth_radix4_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
);

    localparam int K  = N / 2 + 1;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [N+1:0]   m_q, m_d;
    logic signed [N+1:0]   h_q, h_d;
    logic        [N+1:0]   q_q, q_d;
    logic                  qm1_q, qm1_d;
    logic        [CW-1:0]  cnt_q, cnt_d;
    logic        [2*N-1:0] result_q, result_d;

    logic signed [N+2:0]   h_ext, m_ext, addend, h_sum;

    // Booth digit from {Q[1],Q[0],Q_-1}, accumulated with one guard bit.
    always_comb begin
        h_ext = {h_q[N+1], h_q};
        m_ext = {m_q[N+1], m_q};
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext <<< 1;
            3'b100:         addend = -(m_ext <<< 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        h_sum = h_ext + addend;
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        h_d      = h_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    m_d     = signed_mode ? {{2{A[N-1]}}, A} : {2'b00, A};
                    q_d     = signed_mode ? {{2{B[N-1]}}, B} : {2'b00, B};
                    h_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(K);
                end
            end
            RUN: begin
                // Arithmetic shift of {H_sum, Q, Q_-1} by two places.
                h_d   = {h_sum[N+2], h_sum[N+2:2]};
                q_d   = {h_sum[1:0], q_q[N+1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = DONE;
                    result_d = {h_sum[N-1:0], q_q[N+1:2]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            h_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            h_q      <= h_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult: directed N=8 vectors and sequences,
// then randomized operations on N=4, 8 and 16 against an arithmetic product model.
module tb_booth_radix4_mult;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        st4 = 1'b0, sm4 = 1'b0, busy4, done4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  res4;
    logic        st8 = 1'b0, sm8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] res8;
    logic        st16 = 1'b0, sm16 = 1'b0, busy16, done16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] res16;

    booth_radix4_mult #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .signed_mode(sm4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .result(res4));
    booth_radix4_mult #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .signed_mode(sm8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .result(res8));
    booth_radix4_mult #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(st16), .signed_mode(sm16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .result(res16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic sm,
                         input logic [15:0] a, input logic [15:0] b);
        case (w)
            4: begin st4 = st; sm4 = sm; a4 = a[3:0]; b4 = b[3:0]; end
            8: begin st8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
            default: begin st16 = st; sm16 = sm; a16 = a; b16 = b; end
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4: return done4;
            8: return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int w);
        case (w)
            4: return {24'b0, res4};
            8: return {16'b0, res8};
            default: return res16;
        endcase
    endfunction

    // Reference: interpret operands per mode, multiply as integers, keep 2w bits.
    function automatic logic [31:0] ref_prod(input int w, input logic sm,
                                             input logic [15:0] a, input logic [15:0] b);
        longint mask, av, bv, p;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (sm && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
        if (sm && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
        p = av * bv;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 1;
        case ($urandom_range(0, 9))
            0: return 16'd0;
            1: return mask[15:0];
            2: return 16'(32'd1 << (w - 1));
            3: return 16'((32'd1 << (w - 1)) - 1);
            default: return 16'($urandom & mask);
        endcase
    endfunction

    // Caller is #1 after an edge with the DUT idle or in DONE; returns in the DONE cycle.
    task automatic run_op(input int w, input logic sm, input logic [15:0] a,
                          input logic [15:0] b, output logic [31:0] r, output int lat);
        logic got;
        drive(w, 1'b1, sm, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, ~sm, 16'($urandom), 16'($urandom));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            got = get_done(w);
        end
        r = get_res(w);
    endtask

    logic [31:0] r;
    int          lat;
    int          ndone;
    logic [15:0] ra, rb;
    logic        rsm;

    initial begin
        vecs[0] = '{1'b1, 8'hF8, 8'h05, 16'hFFD8};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[6] = '{1'b0, 8'h00, 8'hFF, 16'h0000};
        vecs[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[8] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[9] = '{1'b1, 8'h05, 8'hF8, 16'hFFD8};

        // Reset state, and start ignored while reset is low.
        st8 = 1'b1; a8 = 8'h55; b8 = 8'h33;
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_result", res8, 0);
        @(posedge clk); #1;
        check("rst_start_ignored_busy", busy8, 0);
        st8 = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, including latency of K=5 edges after acceptance.
        for (int i = 0; i < 10; i++) begin
            run_op(8, vecs[i].sm, {8'h0, vecs[i].a}, {8'h0, vecs[i].b}, r, lat);
            check($sformatf("vec%0d_result", i), r, {16'h0, vecs[i].exp});
            check($sformatf("vec%0d_latency", i), lat, 5);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_one_cycle", i), done8, 0);
        end

        // Back-to-back with start held high, operand change mid-RUN.
        drive(8, 1'b1, 1'b0, 16'd3, 16'd7);
        @(posedge clk); #1;
        check("b2b_busy", busy8, 1);
        drive(8, 1'b1, 1'b0, 16'h10, 16'h10);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_latency", lat, 5);
        check("b2b_first_result", res8, 16'h0015);
        lat = 0;
        ndone = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) check("b2b_result_held", res8, 16'h0015);
            st8 = (lat % 2 == 0);
        end while (!done8 && lat < 40);
        st8 = 1'b0;
        check("b2b_spacing", lat, 6);
        check("b2b_second_result", res8, 16'h0100);
        @(posedge clk); #1;
        check("b2b_idle_done", done8, 0);
        check("b2b_idle_busy", busy8, 0);
        check("b2b_idle_result", res8, 16'h0100);

        // Reset asserted three cycles into RUN.
        drive(8, 1'b1, 1'b0, 16'd9, 16'd9);
        @(posedge clk); #1;
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_busy", busy8, 0);
        check("midrst_done", done8, 0);
        check("midrst_result", res8, 0);
        ndone = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        #2;
        rst = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_op(8, 1'b0, 16'd2, 16'd3, r, lat);
        check("midrst_next_result", r, 32'h6);
        check("midrst_next_latency", lat, 5);
        @(posedge clk); #1;

        // Randomized operations on each width.
        for (int w = 4; w <= 16; w *= 2) begin
            for (int i = 0; i < 3334; i++) begin
                ra  = pick(w);
                rb  = pick(w);
                rsm = 1'($urandom_range(0, 1));
                run_op(w, rsm, ra, rb, r, lat);
                if (r !== ref_prod(w, rsm, ra, rb))
                    check($sformatf("rand_n%0d_s%0d_%0h_x_%0h", w, rsm, ra, rb), r, ref_prod(w, rsm, ra, rb));
                else
                    checks++;
                check($sformatf("rand_n%0d_latency", w), lat, w / 2 + 1);
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_radix4_mult.md
BOOTH_RADIX4_MULT -- requirements
Module: booth_radix4_mult

Interface
REQ-001 Parameter N, default 8: operand width; SHALL be even and >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  request to begin a multiply; sampled on rising clk edges.
REQ-005 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
REQ-006 A  input  N  multiplicand; captured on start acceptance.
REQ-007 B  input  N  multiplier; captured on start acceptance.
REQ-008 busy  output  1  high while an iteration sequence is in progress.
REQ-009 done  output  1  single-cycle pulse marking result valid.
REQ-010 result  output  2N  product, registered, held until the next accepted start completes.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE).
REQ-012 start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored with no effect on the operation.
REQ-013 On acceptance, the block SHALL capture signed_mode, load M = A extended to N+2 bits (sign-extended if signed_mode, zero-extended otherwise), load multiplier Q = B extended likewise to N+2 bits, clear accumulator H (N+2 bits), clear Q_-1, load iteration counter with K = N/2+1, and enter RUN.
REQ-014 Each RUN cycle SHALL select the radix-4 digit from {Q[1],Q[0],Q_-1}: 000/111 -> 0, 001/010 -> +M, 011 -> +2M, 100 -> -2M, 101/110 -> -M; add it to H in N+3-bit two's complement.
REQ-015 In the same cycle, {H_sum, Q, Q_-1} SHALL be arithmetically shifted right by 2 (sign of H_sum replicated) and written back; the counter SHALL decrement.
REQ-016 After exactly K RUN cycles, the FSM SHALL enter DONE; result SHALL be loaded with the low 2N bits of {H, Q} on that same edge.
REQ-017 Latency: start accepted at edge t -> done high in the cycle after edge t+K (K+1 cycles); for N=8, done high 6 cycles after acceptance.
REQ-018 DONE SHALL last exactly one cycle; next state SHALL be RUN if start is high, else IDLE (back-to-back supported, no dead cycle).
REQ-019 result SHALL change only on entry to DONE; it SHALL remain stable during IDLE and RUN of a following operation.
REQ-020 Unsigned mode SHALL produce the exact unsigned product for all A, B in [0, 2^N-1]; signed mode the exact two's-complement product for all A, B in [-2^(N-1), 2^(N-1)-1], including A = B = -2^(N-1).
REQ-021 Changes on A, B, signed_mode after acceptance SHALL not affect the operation in progress.
REQ-022 Latency SHALL be identical in both modes and independent of operand values.

Reset
REQ-023 While rst = 0, state SHALL be IDLE, busy = 0, done = 0, result = 0, and all internal registers (M, H, Q, Q_-1, counter, captured mode) = 0, immediately without a clock edge.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst returns to 1 SHALL behave as from power-up.
REQ-025 start SHALL not be accepted on the first rising edge at which rst is low.

Verification
REQ-026 N=8, signed_mode=1, A=0xF8 (-8), B=0x05 -> done 6 cycles after acceptance, result = 0xFFD8 (-40).
REQ-027 N=8, signed_mode=0, A=0xFF, B=0xFF -> result = 0xFE01; signed_mode=1 same operands -> result = 0x0001.
REQ-028 N=8, signed_mode=1, A=0x80, B=0x80 -> result = 0x4000; A=0x80, B=0x7F -> result = 0xC080.
REQ-029 N=8, start held high through DONE with A=3,B=7 then A=0x10,B=0x10 unsigned -> done pulses 6 cycles apart, results 0x0015 then 0x0100; start pulses during RUN ignored.
REQ-030 rst driven low 3 cycles into RUN -> busy, done, result go 0 immediately; no done pulse; next op 2*3 unsigned -> 0x0006.
REQ-031 Randomised self-check, N in {4, 8, 16}, both modes, >= 10,000 ops against a reference product, including 0, max, min operands.
